// File: rtl/matmul_tile_scheduler_pkg.sv
// matmul_sched_pkg: FSM encoding, derived tile sizes and the
// dimension check shared by the tile scheduler files.
package matmul_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN
    } state_t;

    localparam int CNT_W = 16;

    function automatic int row_size(input int i_outer, input int bs);
        return i_outer / bs;
    endfunction

    function automatic int col_size(input int w_outer, input int bs);
        return w_outer / bs;
    endfunction

    function automatic int inner_steps(input int inner, input int bs);
        return inner / bs;
    endfunction

    function automatic int max_flag(input int i_outer, input int w_outer,
                                    input int bs);
        return row_size(i_outer, bs) * col_size(w_outer, bs);
    endfunction

    function automatic bit dims_ok(input int width, input int bs,
                                   input int inner, input int i_outer,
                                   input int w_outer, input int bram_lat,
                                   input int result_lat);
        return (width > 0) && (bs > 0)
            && (inner >= bs) && (inner % bs == 0)
            && (i_outer >= bs) && (i_outer % bs == 0)
            && (w_outer >= bs) && (w_outer % bs == 0)
            && (bram_lat >= 1) && (result_lat >= 1);
    endfunction

endpackage

// File: rtl/matmul_tile_scheduler_if.sv
// Handshake/strobe bundle between the tile scheduler (master) and the
// BRAM ports, MAC array and host (slave). Clock/reset stay outside.
interface matmul_tile_scheduler_if #(
    parameter int IN_ADDR_W  = 14,
    parameter int WB_ADDR_W  = 12,
    parameter int OUT_ADDR_W = 14
);
    logic                  start;
    logic                  ready;
    logic                  done;
    logic                  rd_en;
    logic [IN_ADDR_W-1:0]  in_addrb;
    logic [WB_ADDR_W-1:0]  wb_addrb;
    logic                  mac_en;
    logic                  mac_first;
    logic                  mac_last;
    logic                  out_we;
    logic [OUT_ADDR_W-1:0] out_addra;
    logic [31:0]           cycle_cnt;

    modport master (
        input  start,
        output ready, done, rd_en, in_addrb, wb_addrb,
        output mac_en, mac_first, mac_last,
        output out_we, out_addra, cycle_cnt
    );

    modport slave (
        output start,
        input  ready, done, rd_en, in_addrb, wb_addrb,
        input  mac_en, mac_first, mac_last,
        input  out_we, out_addra, cycle_cnt
    );
endinterface

// File: rtl/matmul_tile_scheduler_delay_line.sv
// sched_delay_line: DEPTH-stage shift register, cleared by sync reset.
// Ports: clk, rst_n, i_d (W bits in), o_q (i_d delayed DEPTH cycles).
module sched_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_sh [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_sh[i] <= '0;
        end else begin
            r_sh[0] <= i_d;
            for (int i = 1; i < DEPTH; i++)
                r_sh[i] <= r_sh[i-1];
        end
    end

    assign o_q = r_sh[DEPTH-1];
endmodule

// File: rtl/matmul_tile_scheduler.sv
// Tile sequencer for C = I x W: walks blocks (r,c) and inner steps k,
// issues BRAM reads, delayed MAC strobes and one output write per block.
// Ports: clk, rst_n (sync, active low), bus (master modport: start,
// ready, done, rd_en, in/wb addresses, mac_*, out_we/out_addra,
// cycle_cnt). Optional perf counter: define MATMUL_SCHED_PERF_EN.
module matmul_tile_scheduler
    import matmul_sched_pkg::*;
#(
    parameter int WIDTH             = 16,
    parameter int BLOCK_SIZE        = 2,
    parameter int INNER_DIMENSION   = 4,
    parameter int I_OUTER_DIMENSION = 6,
    parameter int W_OUTER_DIMENSION = 6,
    parameter int BRAM_LAT          = 1,
    parameter int RESULT_LAT        = 2,
    parameter int IN_ADDR_W         = 14,
    parameter int WB_ADDR_W         = 12,
    parameter int OUT_ADDR_W        = 14
) (
    input logic clk,
    input logic rst_n,
    matmul_tile_scheduler_if.master bus
);
    localparam int RS = row_size(I_OUTER_DIMENSION, BLOCK_SIZE);
    localparam int CS = col_size(W_OUTER_DIMENSION, BLOCK_SIZE);
    localparam int IS = inner_steps(INNER_DIMENSION, BLOCK_SIZE);
    localparam int MF = max_flag(I_OUTER_DIMENSION,
                                 W_OUTER_DIMENSION, BLOCK_SIZE);
    localparam int MW = 3 + OUT_ADDR_W;
    localparam int OW = 1 + OUT_ADDR_W;

    if (!dims_ok(WIDTH, BLOCK_SIZE, INNER_DIMENSION,
                 I_OUTER_DIMENSION, W_OUTER_DIMENSION,
                 BRAM_LAT, RESULT_LAT)) begin : g_bad_dims
        $error("matmul_tile_scheduler: bad dimensions or latencies");
    end

    state_t                r_state;
    logic [CNT_W-1:0]      r_r, r_c, r_k;
    logic                  r_ready, r_done;
    logic                  r_rd_en, r_first, r_last;
    logic [IN_ADDR_W-1:0]  r_in_addr;
    logic [WB_ADDR_W-1:0]  r_wb_addr;
    logic [OUT_ADDR_W-1:0] r_flag;

    logic                  w_k_end, w_c_end, w_r_end, w_fin;
    logic [CNT_W-1:0]      w_nk, w_nc, w_nr;
    logic [MW-1:0]         w_mac_d, w_mac_q;
    logic [OW-1:0]         w_out_d, w_out_q;
    logic                  w_mac_last, w_final;
    logic [OUT_ADDR_W-1:0] w_mac_flag;

    always_comb begin
        w_k_end = (r_k == CNT_W'(IS - 1));
        w_c_end = (r_c == CNT_W'(CS - 1));
        w_r_end = (r_r == CNT_W'(RS - 1));
        w_fin   = w_k_end && w_c_end && w_r_end;
        w_nk    = w_k_end ? '0 : r_k + 1'b1;
        w_nc    = r_c;
        w_nr    = r_r;
        if (w_k_end) begin
            w_nc = w_c_end ? '0 : r_c + 1'b1;
            if (w_c_end)
                w_nr = r_r + 1'b1;
        end
    end

    // Block index rides with the strobes so out_addra matches out_we.
    assign w_mac_d = {r_rd_en, r_first, r_last, r_flag};

    sched_delay_line #(.DEPTH(BRAM_LAT), .W(MW)) u_mac_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_mac_d),
        .o_q   (w_mac_q)
    );

    assign w_mac_last = w_mac_q[MW-3];
    assign w_mac_flag = w_mac_q[OUT_ADDR_W-1:0];
    assign w_out_d    = {w_mac_last, w_mac_last ? w_mac_flag : '0};

    sched_delay_line #(.DEPTH(RESULT_LAT), .W(OW)) u_out_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_out_d),
        .o_q   (w_out_q)
    );

    assign w_final = w_out_q[OUT_ADDR_W]
        && (w_out_q[OUT_ADDR_W-1:0] == OUT_ADDR_W'(MF - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_r       <= '0;
            r_c       <= '0;
            r_k       <= '0;
            r_in_addr <= '0;
            r_wb_addr <= '0;
            r_flag    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state   <= S_FEED;
                        r_ready   <= 1'b0;
                        r_rd_en   <= 1'b1;
                        r_first   <= 1'b1;
                        r_last    <= (IS == 1);
                        r_r       <= '0;
                        r_c       <= '0;
                        r_k       <= '0;
                        r_in_addr <= '0;
                        r_wb_addr <= '0;
                        r_flag    <= '0;
                    end
                end
                S_FEED: begin
                    if (w_fin) begin
                        r_state   <= S_DRAIN;
                        r_rd_en   <= 1'b0;
                        r_first   <= 1'b0;
                        r_last    <= 1'b0;
                        r_in_addr <= '0;
                        r_wb_addr <= '0;
                        r_flag    <= '0;
                    end else begin
                        r_k       <= w_nk;
                        r_c       <= w_nc;
                        r_r       <= w_nr;
                        r_first   <= (w_nk == '0);
                        r_last    <= (w_nk == CNT_W'(IS - 1));
                        r_in_addr <= IN_ADDR_W'(w_nr * IS + w_nk);
                        r_wb_addr <= WB_ADDR_W'(w_nc * IS + w_nk);
                        r_flag    <= OUT_ADDR_W'(w_nr * CS + w_nc);
                    end
                end
                S_DRAIN: begin
                    if (w_final) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready     = r_ready;
    assign bus.done      = r_done;
    assign bus.rd_en     = r_rd_en;
    assign bus.in_addrb  = r_in_addr;
    assign bus.wb_addrb  = r_wb_addr;
    assign bus.mac_en    = w_mac_q[MW-1];
    assign bus.mac_first = w_mac_q[MW-2];
    assign bus.mac_last  = w_mac_last;
    assign bus.out_we    = w_out_q[OUT_ADDR_W];
    assign bus.out_addra = w_out_q[OUT_ADDR_W-1:0];

`ifdef MATMUL_SCHED_PERF_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cycle_cnt <= '0;
        else if (r_state == S_IDLE) begin
            if (bus.start)
                r_cycle_cnt <= '0;
        end else
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end

    assign bus.cycle_cnt = r_cycle_cnt;
`else
    assign bus.cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: three configurations driven by the
// same start/rst_n, each checked every cycle against a run-offset model.
module tb_matmul_tile_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    localparam int NCFG = 3;
    localparam int CFG_INNER [NCFG] = '{4, 4, 2};
    localparam int CFG_BL    [NCFG] = '{1, 2, 1};
    localparam int CFG_RL    [NCFG] = '{2, 3, 2};
    localparam int LIT_MAC   [NCFG] = '{2, 3, 2};
    localparam int LIT_WE    [NCFG] = '{5, 7, 4};
    localparam int LIT_DONE  [NCFG] = '{22, 24, 13};
`ifdef MATMUL_SCHED_PERF_EN
    localparam int LIT_CNT   [NCFG] = '{21, 23, 12};
`else
    localparam int LIT_CNT   [NCFG] = '{0, 0, 0};
`endif
    localparam int LIT_IN [NCFG][8] = '{
        '{0, 1, 0, 1, 0, 1, 2, 3},
        '{0, 1, 0, 1, 0, 1, 2, 3},
        '{0, 0, 0, 1, 1, 1, 2, 2}};
    localparam int LIT_WB [NCFG][8] = '{
        '{0, 1, 2, 3, 4, 5, 0, 1},
        '{0, 1, 2, 3, 4, 5, 0, 1},
        '{0, 1, 2, 0, 1, 2, 0, 1}};

    task automatic chk(input string nm, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0d expected %0d",
                     g, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int BS    = 2;
        localparam int IO    = 6;
        localparam int WO    = 6;
        localparam int INN   = CFG_INNER[g];
        localparam int BL    = CFG_BL[g];
        localparam int RL    = CFG_RL[g];
        localparam int IS    = INN / BS;
        localparam int C     = WO / BS;
        localparam int R     = IO / BS;
        localparam int MAXF  = R * C;
        localparam int TOTAL = MAXF * IS;
        localparam int ENDT  = TOTAL + BL + RL + 1;

        matmul_tile_scheduler_if bus ();
        assign bus.start = start;

        matmul_tile_scheduler #(
            .WIDTH(16), .BLOCK_SIZE(BS), .INNER_DIMENSION(INN),
            .I_OUTER_DIMENSION(IO), .W_OUTER_DIMENSION(WO),
            .BRAM_LAT(BL), .RESULT_LAT(RL),
            .IN_ADDR_W(14), .WB_ADDR_W(12), .OUT_ADDR_W(14)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // t = cycle number within the current run (1 = first issue);
        // -1 after reset before any start.
        int t = -1;
        int run_no = 0;
        bit seen_rst = 1'b0;
        int first_mac = -1, first_we = -1, done_t = -1, cnt_done = -1;
        int n_rec = 0;
        int rec_in [8] = '{default: -1};
        int rec_wb [8] = '{default: -1};
        int i, j, m, blk, ecnt;
        bit rd, mac, we;

        always @(posedge clk) begin
            if (!rst_n) begin
                t = -1;
                seen_rst = 1'b1;
            end else if (start && (t < 1 || t >= ENDT)) begin
                t = 1;
                run_no++;
            end else if (t >= 1 && t < 100000) begin
                t++;
            end
        end

        always @(negedge clk) begin
            if (seen_rst) begin
                i   = t - 1;
                rd  = (t >= 1) && (i < TOTAL);
                chk("rd_en", g, bus.rd_en, rd);
                if (rd) begin
                    blk = i / IS;
                    chk("in_addrb", g, bus.in_addrb,
                        (blk / C) * IS + i % IS);
                    chk("wb_addrb", g, bus.wb_addrb,
                        (blk % C) * IS + i % IS);
                end
                j   = t - 1 - BL;
                mac = (t >= 1) && (j >= 0) && (j < TOTAL);
                chk("mac_en", g, bus.mac_en, mac);
                chk("mac_first", g, bus.mac_first,
                    mac && (j % IS == 0));
                chk("mac_last", g, bus.mac_last,
                    mac && (j % IS == IS - 1));
                m  = t - BL - RL;
                we = (t >= 1) && (m >= IS) && (m % IS == 0)
                     && (m / IS <= MAXF);
                chk("out_we", g, bus.out_we, we);
                if (we)
                    chk("out_addra", g, bus.out_addra, m / IS - 1);
                chk("done", g, bus.done, t == ENDT);
                chk("ready", g, bus.ready, (t < 1) || (t >= ENDT));
`ifdef MATMUL_SCHED_PERF_EN
                ecnt = (t < 1) ? 0 : ((t < ENDT) ? t - 1 : ENDT - 1);
`else
                ecnt = 0;
`endif
                chk("cycle_cnt", g, bus.cycle_cnt, ecnt);
                if (run_no == 1) begin
                    if (bus.mac_en === 1'b1 && first_mac < 0)
                        first_mac = t;
                    if (bus.out_we === 1'b1 && first_we < 0)
                        first_we = t;
                    if (bus.done === 1'b1 && done_t < 0) begin
                        done_t   = t;
                        cnt_done = int'(bus.cycle_cnt);
                    end
                    if (bus.rd_en === 1'b1 && n_rec < 8) begin
                        rec_in[n_rec] = int'(bus.in_addrb);
                        rec_wb[n_rec] = int'(bus.wb_addrb);
                        n_rec++;
                    end
                end
            end
        end

        initial begin
            wait (stim_done);
            chk("lit_first_mac", g, first_mac, LIT_MAC[g]);
            chk("lit_first_we", g, first_we, LIT_WE[g]);
            chk("lit_done", g, done_t, LIT_DONE[g]);
            chk("lit_cnt_at_done", g, cnt_done, LIT_CNT[g]);
            for (int k = 0; k < 8; k++) begin
                chk("lit_in_seq", g, rec_in[k], LIT_IN[g][k]);
                chk("lit_wb_seq", g, rec_wb[k], LIT_WB[g][k]);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        repeat (60) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        repeat (400) begin
            start = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 39) != 0);
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        stim_done = 1'b1;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/matmul_tile_scheduler.md
# matmul_tile_scheduler

Sequencer for the Multi MAC matrix-multiply datapath. After `start`, it walks every output block of C = I × W and, for each block, steps through the inner-dimension chunks. Each step issues paired read addresses to the input BRAM and the weight/bias BRAM. The MAC array receives delayed enable, first and last strobes, and the output BRAM receives one write strobe with address per completed block. It sits inside `top` between the BRAM read ports and the systolic array, replacing ad-hoc counter logic.

## Interface
- `WIDTH`, 16, element width (pass-through only, for package consistency)
- `BLOCK_SIZE`, 2, systolic array dimension N
- `INNER_DIMENSION`, 4, shared dimension of I and W
- `I_OUTER_DIMENSION`, 6, rows of I
- `W_OUTER_DIMENSION`, 6, columns of W
- `BRAM_LAT`, 1, cycles from read address to data at MAC input (≥1)
- `RESULT_LAT`, 2, cycles from `mac_last` to block result valid (≥1)
- `IN_ADDR_W`, 14; `WB_ADDR_W`, 12; `OUT_ADDR_W`, 14: address widths
- Derived: ROW_SIZE_MAT_C = I_OUTER/BLOCK_SIZE; COL_SIZE_MAT_C = W_OUTER/BLOCK_SIZE; INNER_STEPS = INNER_DIMENSION/BLOCK_SIZE; MAX_FLAG = ROW_SIZE_MAT_C·COL_SIZE_MAT_C

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `start` in 1: run request, sampled only when `ready`=1
- `ready` out 1: idle, can accept `start`
- `done` out 1: one-cycle pulse, run finished
- `rd_en` out 1: read enable for both BRAMs
- `in_addrb` out IN_ADDR_W: input BRAM read address
- `wb_addrb` out WB_ADDR_W: weight/bias BRAM read address
- `mac_en` out 1: MAC array consumes data this cycle
- `mac_first` out 1: first inner step of block (clear accumulator)
- `mac_last` out 1: last inner step of block
- `out_we` out 1: write block result
- `out_addra` out OUT_ADDR_W: output BRAM write address (block index)
- `cycle_cnt` out 32: performance counter (see Configuration)

## Operation
- FSM states: IDLE, FEED, DRAIN. IDLE→FEED on `start`&`ready`. FEED→DRAIN after the last issue. DRAIN→IDLE on the cycle the final `out_we` is registered. `done` pulses and `ready` rises the cycle after that.
- Counters `r` (0..ROW_SIZE_MAT_C-1), `c` (0..COL_SIZE_MAT_C-1) and `k` (0..INNER_STEPS-1) nest with `k` innermost, then `c`, then `r`.
- Address mapping: `in_addrb` = r·INNER_STEPS + k; `wb_addrb` = c·INNER_STEPS + k; `out_addra` = r·COL_SIZE_MAT_C + c (= flag, 0..MAX_FLAG-1).
- One issue per FEED cycle, no bubbles; total issues = MAX_FLAG·INNER_STEPS.
- `mac_en`/`mac_first`/`mac_last` are `rd_en` and `k==0`/`k==INNER_STEPS-1` delayed by BRAM_LAT.
- `out_we` is `mac_last` delayed by RESULT_LAT; `out_addra` travels with it.
- INNER_STEPS=1: `mac_first` and `mac_last` assert together every cycle.
- `start` while busy is ignored. `start` with `rst_n`=0: reset wins.
- Reset, including mid-run: state IDLE, counters and delay lines cleared, in-flight strobes dropped. Outputs: `ready`=1, all other outputs 0.
- Elaboration error if any dimension is not divisible by BLOCK_SIZE.

## Timing
- All outputs are registered.
- `start` sampled at edge E0 → first issue (`rd_en`=1, addresses 0/0) visible after E0 (cycle 1). `ready` is 0 from cycle 1.
- Issues occupy cycles 1..MAX_FLAG·INNER_STEPS.
- Block b's `out_we` occurs at cycle (b+1)·INNER_STEPS + BRAM_LAT + RESULT_LAT.
- `done` and `ready` assert at cycle MAX_FLAG·INNER_STEPS + BRAM_LAT + RESULT_LAT + 1. With defaults this is cycle 22, and `start` may be accepted at edge E22.

## Configuration
- `MATMUL_SCHED_PERF_EN` defined: `cycle_cnt` clears on `start` acceptance, increments every non-IDLE cycle, and holds its value after `done` until the next `start` or reset. With defaults it reads 21 when `done` is high.
- Not defined: `cycle_cnt` is tied to 0 and no counter logic is built.

## Structure
- Package `matmul_sched_pkg`: FSM state encoding, derived-size localparams/functions (ROW_SIZE_MAT_C, COL_SIZE_MAT_C, INNER_STEPS, MAX_FLAG), and the divisibility check.
- Sub-module `sched_delay_line` (params DEPTH, W): reset-clearable shift register. Instantiated once for the MAC strobes and once for `out_we`/`out_addra`.

## Test plan
- Defaults, `start` pulse at E0 → 18 issues with `in_addrb` sequence 0,1,0,1,0,1,2,3,… and `wb_addrb` sequence 0,1,2,3,4,5,0,1,…; `out_we` at cycles 5,7,…,21 with `out_addra` 0..8; `done` at cycle 22.
- `start` held high for the whole run → exactly one run; second run accepted at E22 and repeats the identical sequence.
- `rst_n` low for one cycle at cycle 10 → outputs 0 and `ready`=1 next cycle; no further `out_we`; a new `start` gives a clean full sequence.
- INNER_DIMENSION=2, BLOCK_SIZE=2 → `mac_first`=`mac_last` on every `mac_en`; `out_we` every cycle from cycle 4 to 12; `done` at cycle 13.
- BRAM_LAT=2, RESULT_LAT=3 → `mac_en` first at cycle 3; first `out_we` at cycle 7; `done` at cycle 24.
- With `MATMUL_SCHED_PERF_EN`, defaults → `cycle_cnt`=21 at `done`, reset to 0 by `rst_n`.
